// File: rtl/sequencer_step_engine.sv
// Multi-channel step sequencer: scans STEPS steps and drives one gated square wave per channel.
// Define SEQ_SWING_EN to implement the SWING register (address 3) that lengthens odd steps.
module sequencer_step_engine #(
  parameter int unsigned STEPS    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = 28,
  localparam int unsigned IDX_W   = $clog2(STEPS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_en,
  input  logic [4:0]          i_wr_addr,
  input  logic [31:0]         i_wr_data,
  output logic [CHANNELS-1:0] o_snd_out,
  output logic [STEPS-1:0]    o_step_led,
  output logic [IDX_W-1:0]    o_step_idx,
  output logic                o_step_tick
);

  localparam logic [1:0]       ModeRev  = 2'b01;
  localparam logic [1:0]       ModePing = 2'b10;
  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(STEPS - 1);

  // Configuration registers
  logic                            r_run;
  logic [1:0]                      r_mode;
  logic [DIV_W-1:0]                r_period;
  logic [DIV_W-1:0]                r_gate;
  logic [CHANNELS-1:0][DIV_W-1:0]  r_tone;
  logic [CHANNELS-1:0][STEPS-1:0]  r_pat;

  // Sequencer state
  logic [DIV_W-1:0]                r_step_cnt;
  logic [DIV_W-1:0]                r_gate_cnt;
  logic [IDX_W-1:0]                r_step_idx;
  logic [STEPS-1:0]                r_step_led;
  logic                            r_step_tick;
  logic                            r_dir_up;
  logic [CHANNELS-1:0][DIV_W-1:0]  r_tone_cnt;
  logic [CHANNELS-1:0]             r_square;
  logic [CHANNELS-1:0]             r_snd;

  // Decoded writes and next-state values
  logic                            w_ctrl_we;
  logic                            w_period_we;
  logic                            w_gate_we;
  logic [CHANNELS-1:0]             w_tone_we;
  logic [CHANNELS-1:0]             w_pat_we;
  logic [DIV_W-1:0]                w_step_limit;
  logic                            w_advance;
  logic [DIV_W-1:0]                w_step_cnt_d;
  logic [DIV_W-1:0]                w_gate_cnt_d;
  logic                            w_gate_on;
  logic [IDX_W-1:0]                w_idx_d;
  logic                            w_dir_up_d;
  logic [STEPS-1:0]                w_led_d;
  logic [CHANNELS-1:0][DIV_W-1:0]  w_tone_cnt_d;
  logic [CHANNELS-1:0]             w_square_d;
  logic [CHANNELS-1:0]             w_snd_d;
  logic                            w_unused_data;

  assign w_unused_data = ^i_wr_data;

  always_comb begin
    w_ctrl_we   = i_wr_en && (i_wr_addr == 5'd0);
    w_period_we = i_wr_en && (i_wr_addr == 5'd1);
    w_gate_we   = i_wr_en && (i_wr_addr == 5'd2);
    for (int c = 0; c < CHANNELS; c++) begin
      w_tone_we[c] = i_wr_en && (i_wr_addr == 5'(4 + c));
      w_pat_we[c]  = i_wr_en && (i_wr_addr == 5'(4 + CHANNELS + c));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run    <= 1'b0;
      r_mode   <= 2'b00;
      r_period <= '0;
      r_gate   <= '0;
      r_tone   <= '0;
      r_pat    <= '0;
    end else begin
      if (w_ctrl_we) begin
        r_run  <= i_wr_data[0];
        r_mode <= i_wr_data[2:1];
      end
      if (w_period_we) begin
        r_period <= i_wr_data[DIV_W-1:0];
      end
      if (w_gate_we) begin
        r_gate <= i_wr_data[DIV_W-1:0];
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_tone_we[c]) begin
          r_tone[c] <= i_wr_data[DIV_W-1:0];
        end
        if (w_pat_we[c]) begin
          r_pat[c] <= i_wr_data[STEPS-1:0];
        end
      end
    end
  end

`ifdef SEQ_SWING_EN
  logic [DIV_W-1:0] r_swing;
  logic             w_swing_we;
  logic [DIV_W:0]   w_swing_sum;

  assign w_swing_we = i_wr_en && (i_wr_addr == 5'd3);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_swing <= '0;
    end else if (w_swing_we) begin
      r_swing <= i_wr_data[DIV_W-1:0];
    end
  end

  // Odd steps stretch by SWING; the sum saturates rather than wrapping.
  always_comb begin
    w_swing_sum = {1'b0, r_period} + {1'b0, r_swing};
    if (!r_step_idx[0]) begin
      w_step_limit = r_period;
    end else if (w_swing_sum[DIV_W]) begin
      w_step_limit = '1;
    end else begin
      w_step_limit = w_swing_sum[DIV_W-1:0];
    end
  end
`else
  assign w_step_limit = r_period;
`endif

  // A PERIOD write outranks a terminal count: restart without advancing.
  always_comb begin
    w_advance = r_run && !w_period_we && (r_step_cnt == w_step_limit);
    if (!r_run || w_period_we || w_advance) begin
      w_step_cnt_d = '0;
    end else begin
      w_step_cnt_d = r_step_cnt + DIV_W'(1);
    end

    if (!r_run || w_advance) begin
      w_gate_cnt_d = '0;
    end else if (r_gate_cnt != '1) begin
      w_gate_cnt_d = r_gate_cnt + DIV_W'(1);
    end else begin
      w_gate_cnt_d = r_gate_cnt;
    end
    w_gate_on = (r_gate_cnt < r_gate);
  end

  always_comb begin
    w_idx_d    = r_step_idx;
    w_dir_up_d = r_dir_up;
    if (w_advance) begin
      case (r_mode)
        ModeRev: begin
          w_idx_d = (r_step_idx == '0) ? LastIdx : r_step_idx - IDX_W'(1);
        end
        ModePing: begin
          if (r_dir_up) begin
            if (r_step_idx == LastIdx) begin
              w_idx_d    = r_step_idx - IDX_W'(1);
              w_dir_up_d = 1'b0;
            end else begin
              w_idx_d = r_step_idx + IDX_W'(1);
            end
          end else begin
            if (r_step_idx == '0) begin
              w_idx_d    = IDX_W'(1);
              w_dir_up_d = 1'b1;
            end else begin
              w_idx_d = r_step_idx - IDX_W'(1);
            end
          end
        end
        default: begin
          w_idx_d = (r_step_idx == LastIdx) ? '0 : r_step_idx + IDX_W'(1);
        end
      endcase
    end
    w_led_d = {{(STEPS - 1){1'b0}}, 1'b1} << w_idx_d;
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_tone_cnt_d[c] = r_tone_cnt[c] + DIV_W'(1);
      w_square_d[c]   = r_square[c];
      if (w_tone_we[c]) begin
        w_tone_cnt_d[c] = '0;
        w_square_d[c]   = r_square[c] & (i_wr_data[DIV_W-1:0] != '0);
      end else if (r_tone[c] == '0) begin
        w_tone_cnt_d[c] = '0;
        w_square_d[c]   = 1'b0;
      end else if (r_tone_cnt[c] == r_tone[c]) begin
        w_tone_cnt_d[c] = '0;
        w_square_d[c]   = ~r_square[c];
      end
      w_snd_d[c] = r_square[c] & w_gate_on & r_pat[c][r_step_idx] & r_run;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step_cnt  <= '0;
      r_gate_cnt  <= '0;
      r_step_idx  <= '0;
      r_step_led  <= {{(STEPS - 1){1'b0}}, 1'b1};
      r_step_tick <= 1'b0;
      r_dir_up    <= 1'b1;
      r_tone_cnt  <= '0;
      r_square    <= '0;
      r_snd       <= '0;
    end else begin
      r_step_cnt  <= w_step_cnt_d;
      r_gate_cnt  <= w_gate_cnt_d;
      r_step_idx  <= w_idx_d;
      r_step_led  <= w_led_d;
      r_step_tick <= w_advance;
      r_dir_up    <= w_dir_up_d;
      r_tone_cnt  <= w_tone_cnt_d;
      r_square    <= w_square_d;
      r_snd       <= w_snd_d;
    end
  end

  assign o_snd_out   = r_snd;
  assign o_step_led  = r_step_led;
  assign o_step_idx  = r_step_idx;
  assign o_step_tick = r_step_tick;

endmodule

// File: tb/tb_sequencer_step_engine.sv
// Scoreboard bench: the driver queues expected step events before starting each run and a
// negedge monitor checks index, LED, step length and the snd_out[0] waveform at every tick.
module tb_sequencer_step_engine;

  localparam int STEPS    = 8;
  localparam int CHANNELS = 2;
  localparam int DIV_W    = 28;
  localparam int IDX_W    = $clog2(STEPS);

  logic                clk     = 1'b0;
  logic                rst_n   = 1'b0;
  logic                wr_en   = 1'b0;
  logic [4:0]          wr_addr = '0;
  logic [31:0]         wr_data = '0;
  logic [CHANNELS-1:0] snd_out;
  logic [STEPS-1:0]    step_led;
  logic [IDX_W-1:0]    step_idx;
  logic                step_tick;

  // idx: index after the tick; gap: cycles since previous tick or run-start write (0 = skip);
  // pat: snd_out[0] over the step just ended, newest sample in bit 0; plen: bits checked.
  typedef struct packed {
    int idx;
    int gap;
    int pat;
    int plen;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          total    = 0;
  int          bad      = 0;
  int          cyc      = 0;
  int          drv_mark = 0;
  int          mon_mark = 0;
  int          prev_idx = 0;
  logic [31:0] hist     = '0;
  logic [31:0] hist_now;

  sequencer_step_engine #(
    .STEPS   (STEPS),
    .CHANNELS(CHANNELS),
    .DIV_W   (DIV_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_snd_out  (snd_out),
    .o_step_led (step_led),
    .o_step_idx (step_idx),
    .o_step_tick(step_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hist     <= '0;
      prev_idx <= 0;
    end else begin
      hist_now = {hist[30:0], snd_out[0]};
      hist     <= hist_now;
      if (step_tick) begin
        if (q.size() == 0) begin
          chk("unexpected_tick", int'(step_idx), -1);
        end else begin
          mon_e = q.pop_front();
          chk("tick_idx", int'(step_idx), mon_e.idx);
          chk("tick_led", int'(step_led), 1 << mon_e.idx);
          if (mon_e.gap != 0)
            chk("step_len", cyc - ((drv_mark > mon_mark) ? drv_mark : mon_mark), mon_e.gap);
          if (mon_e.plen != 0)
            chk("snd_pattern", int'(hist_now & ((32'd1 << mon_e.plen) - 32'd1)), mon_e.pat);
        end
        mon_mark <= cyc;
      end else begin
        chk("idx_hold", int'(step_idx), prev_idx);
      end
      prev_idx <= int'(step_idx);
    end
  end

  task automatic expect_tick(input int idx, input int gap, input int pat, input int plen);
    exp_t e;
    e.idx  = idx;
    e.gap  = gap;
    e.pat  = pat;
    e.plen = plen;
    q.push_back(e);
  endtask

  // Drive a write captured at posedge number e; optionally mark e as the step-length origin.
  task automatic wr_at(input int e, input int addr, input int data, input bit set_mark);
    while (cyc < e - 1) @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 5'(addr);
    wr_data = 32'(data);
    if (set_mark) drv_mark = e;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wr(input int addr, input int data, input bit set_mark);
    wr_at(cyc + 1, addr, data, set_mark);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  // Asynchronous reset asserted between edges, while the previous test may still be running.
  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    chk("rst_idx", int'(step_idx), 0);
    chk("rst_led", int'(step_led), 1);
    chk("rst_tick", int'(step_tick), 0);
    chk("rst_snd", int'(snd_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_led", int'(step_led), 1);
    chk("rel_snd", int'(snd_out), 0);
  endtask

  initial begin
    int r;
    int pp[16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_idx", int'(step_idx), 0);
    chk("init_led", int'(step_led), 1);
    chk("init_tick", int'(step_tick), 0);
    chk("init_snd", int'(snd_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Forward scan, tone muted by TONE[0]=0 despite an all-ones pattern
    wr(1, 3, 1'b0);
    wr(2, 2, 1'b0);
    wr(4, 0, 1'b0);
    wr(4 + CHANNELS, 'hFF, 1'b0);
    for (int i = 1; i <= 9; i++) expect_tick(i % STEPS, 4, 0, 4);
    wr(0, 1, 1'b1);
    drain(200);
    reset_dut();

    // Gating: square toggles every 2 cycles, audible only in the first 4 cycles of steps 0 and 2
    wr(1, 9, 1'b0);
    wr(2, 4, 1'b0);
    wr(4 + CHANNELS, 'h05, 1'b0);
    wr(4, 1, 1'b0);
    for (int i = 1; i <= 9; i++)
      expect_tick(i % STEPS, 10, (((i - 1) % STEPS == 0) || ((i - 1) % STEPS == 2)) ? 'h180 : 0,
                  10);
    wr(0, 1, 1'b1);
    drain(300);
    reset_dut();

    // GATE > PERIOD keeps the whole step audible; GATE=0 then mutes from step 2 on
    wr(1, 3, 1'b0);
    wr(2, 100, 1'b0);
    wr(4 + CHANNELS, 'hFF, 1'b0);
    wr(4, 1, 1'b0);
    expect_tick(1, 4, 'h6, 4);
    expect_tick(2, 4, 'h6, 4);
    expect_tick(3, 4, 0, 4);
    expect_tick(4, 4, 0, 4);
    wr(0, 1, 1'b1);
    r = cyc;
    wr_at(r + 8, 2, 0, 1'b0);
    drain(200);
    reset_dut();

    // Ping-pong with PERIOD=0: one step per cycle, endpoints not repeated
    for (int i = 0; i < 16; i++) expect_tick(pp[i], 1, 0, 0);
    wr(0, 5, 1'b1);
    drain(100);
    reset_dut();

    // Ping-pong up to 2, reverse through the wrap, back to ping-pong with direction still up
    wr(1, 3, 1'b0);
    expect_tick(1, 4, 0, 0);
    expect_tick(2, 4, 0, 0);
    expect_tick(1, 4, 0, 0);
    expect_tick(0, 4, 0, 0);
    expect_tick(7, 4, 0, 0);
    expect_tick(6, 4, 0, 0);
    expect_tick(5, 4, 0, 0);
    wr(0, 5, 1'b1);
    r = cyc;
    wr_at(r + 9, 0, 3, 1'b0);
    wr_at(r + 21, 0, 5, 1'b0);
    drain(200);
    reset_dut();

    // PERIOD 7 -> 2 written while the step counter is at 5
    wr(1, 7, 1'b0);
    expect_tick(1, 3, 0, 0);
    expect_tick(2, 3, 0, 0);
    wr(0, 1, 1'b1);
    r = cyc;
    wr_at(r + 6, 1, 2, 1'b1);
    drain(100);
    reset_dut();

    // Swing on odd steps (address 3 ignored when the feature is not built)
    wr(1, 3, 1'b0);
    wr(3, 2, 1'b0);
`ifdef SEQ_SWING_EN
    expect_tick(1, 4, 0, 0);
    expect_tick(2, 6, 0, 0);
    expect_tick(3, 4, 0, 0);
    expect_tick(4, 6, 0, 0);
`else
    expect_tick(1, 4, 0, 0);
    expect_tick(2, 4, 0, 0);
    expect_tick(3, 4, 0, 0);
    expect_tick(4, 4, 0, 0);
`endif
    wr(0, 1, 1'b1);
    drain(100);
    reset_dut();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sequencer_step_engine.md
# sequencer_step_engine

Parametrised multi-channel step sequencer for the picoversat audio peripheral, replacing the fixed 8-step, single-tone loop controller. Software programs the step period, gate length, per-channel tone half-periods and per-channel step patterns through a word-addressed write port. The block scans the steps in forward, reverse or ping-pong order and drives one gated square-wave output per channel plus a one-hot step indicator for the board LEDs.

## Interface
- `STEPS`, 8: number of sequencer steps, 2..32.
- `CHANNELS`, 2: number of tone channels, 1..8.
- `DIV_W`, 28: width of the period, gate and tone counters and their registers.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  register write strobe, sampled at posedge `clk`.
- `wr_addr`  in  5  register word address.
- `wr_data`  in  32  write data; narrower registers take the LSBs.
- `snd_out`  out  `CHANNELS`  gated square wave per channel.
- `step_led`  out  `STEPS`  one-hot current step.
- `step_idx`  out  `$clog2(STEPS)`  current step index.
- `step_tick`  out  1  one-cycle pulse on every step advance.

## Operation
- Register map: 0 CTRL (bit0 `run`, bits 2:1 `mode`: 00 forward, 01 reverse, 10 ping-pong, 11 forward). 1 PERIOD. 2 GATE. 3 SWING (see Configuration). 4+c TONE[c]. 4+`CHANNELS`+c PAT[c] (`STEPS` bits; bit s enables step s). Writes to unmapped addresses are ignored.
- Step counter: counts 0..PERIOD. On reaching PERIOD it wraps to 0, pulses `step_tick` and advances the step. PERIOD=0 advances the step every cycle.
- Step advance:
  - Forward: +1, wrapping STEPS-1→0.
  - Reverse: −1, wrapping 0→STEPS-1.
  - Ping-pong: an internal direction flag flips at STEPS-1 and at 0. Endpoints are not repeated (0,1,…,N-1,N-2,…,1,0,1…).
  - A mode change takes effect at the next advance. The direction flag is retained across mode changes.
- Gate: the gate counter restarts at every step advance. Gate is high while gate count < GATE. GATE=0 mutes all channels. GATE > PERIOD keeps the gate high for the whole step.
- Tone: each channel has a free-running counter 0..TONE[c]. The channel square wave toggles on terminal count. TONE[c]=0 holds that square wave low. Tone counters run regardless of `run`.
- Output: `snd_out[c]` = square[c] & gate & PAT[c][step_idx] & run.
- `run`=0: step and gate counters are held at 0 and `step_idx` is held. A 0→1 write starts a full-length step at the current index.
- A write to PERIOD while running restarts the step counter at 0 and leaves `step_idx` unchanged. A write to TONE[c] restarts that channel's tone counter.
- Reset (`rst` low, asynchronous):
  - All registers 0 and `run`=0.
  - `step_idx`=0, `step_led`=1, `step_tick`=0, `snd_out`=0.
  - Direction flag set to up.
  - All counters 0.
- Mid-operation reset aborts immediately to these values.

## Timing
- A write takes effect on the capturing edge. Its consequences are visible on outputs in the following cycle.
- `step_tick`, `step_idx` and `step_led` are registered. `step_tick` is high in the first cycle of the new index.
- `snd_out` is registered: one cycle of latency from the internal square, gate and pattern state.
- Step length is PERIOD+1 cycles.
- Gate is high for min(GATE, PERIOD+1) cycles starting at the first cycle of the step.
- The square-wave half-period is TONE[c]+1 cycles.
- Simultaneous wrap of the step counter and a PERIOD write: the write wins, the counter goes to 0 and there is no advance.

## Configuration
- `SEQ_SWING_EN` defined: the SWING register (address 3, `DIV_W` bits) is implemented. Odd-indexed steps last PERIOD+SWING+1 cycles, with overflow saturating at all-ones. Even steps last PERIOD+1 cycles.
- `SEQ_SWING_EN` undefined: address 3 is unmapped and all steps last PERIOD+1 cycles.

## Test plan
- Reset check: hold `rst` low mid-run → all outputs at reset values within the same cycle. Release → `step_led`=1, `snd_out`=0.
- Forward scan: PERIOD=3, GATE=2, TONE[0]=0, run=1, forward → `step_tick` every 4 cycles, `step_idx` 0→1→…→7→0, `snd_out` 0 (tone muted).
- Gating: TONE[0]=1, PAT[0]=8'b0000_0101, PERIOD=9, GATE=4 → `snd_out[0]` toggles every 2 cycles for 4 cycles in steps 0 and 2 only, low elsewhere.
- Ping-pong: `STEPS`=4, PERIOD=0, mode=10 → `step_idx` sequence 0,1,2,3,2,1,0,1. Switching to reverse at index 2 going up → next index 1.
- Mid-run PERIOD write: PERIOD=7, write PERIOD=2 at step counter 5 → next `step_tick` 3 cycles after the write, `step_idx` unchanged until then.
- Swing (`SEQ_SWING_EN`): PERIOD=3, SWING=2 → step lengths alternate 4,6,4,6 cycles. Without the macro, a write to address 3 has no effect and every step lasts 4 cycles.
